param_shift_counter: RTL and testbench
======================================

# param_shift_counter

Parametrised shift-register counter and pulse divider. It is the successor of the fixed ring-counter pulse generator. A circulating-bit register of configurable length runs in either ring (one-hot) or Johnson (twisted-ring) mode. The block emits a single-cycle `count_pulse` on every wrap, exposes the live phase vector, and optionally counts wraps. It sits in the timing/counters area as a low-logic divider for strobes and sequencing enables.

## Interface
- `LENGTH`, default 8: shift-register length in bits; legal range is LENGTH ≥ 2.
- `MODE`, default 0: 0 = ring (period LENGTH), 1 = Johnson (period 2·LENGTH).
- `WRAP_W`, default 8: width of the wrap counter. Used only with `CSR_WRAP_CNT_EN`.
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `enable`  in  1  advances the register by one step per cycle while high.
- `clear`  in  1  synchronous restart to the reset phase.
- `count_pulse`  out  1  registered; high for exactly one cycle per wrap.
- `phase`  out  LENGTH  current shift-register contents.
- `wrap_cnt`  out  WRAP_W  number of wraps since reset/clear, saturating.

## Operation
- Reset phase:
  - Ring: `phase` = 1 (bit 0 set).
  - Johnson: `phase` = 0.
- Ring step: rotate left, so `phase[0]` ← `phase[LENGTH-1]`.
- Johnson step: shift left with `phase[0]` ← ~`phase[LENGTH-1]`.
  - Sequence for LENGTH=4: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then 0000.
- Terminal phase, i.e. the step that returns to the reset phase:
  - Ring: `phase[LENGTH-1]`=1.
  - Johnson: `phase` = only MSB set.
- Wrap: a step taken from the terminal phase. `count_pulse` is high in the cycle following that edge; otherwise it is 0.
- Priority per edge, highest first: `rst` > `clear` > `enable` > hold.
- `rst`: `phase` ← reset phase, `count_pulse` ← 0, `wrap_cnt` ← 0.
- `clear`: same effect as `rst` on all three outputs. It overrides `enable` in the same cycle, and no pulse is generated even if `phase` was terminal.
- `enable` low: `phase` holds and `count_pulse` ← 0. A pulse is never stretched or deferred.
- `wrap_cnt` increments on each wrap and saturates at all-ones. It never wraps to 0.
- Phases outside the legal sequence are unreachable. No recovery logic is required.

## Timing
- All outputs are registered. There is no combinational path from input to output.
- Reset values: `count_pulse`=0, `phase`=reset phase, `wrap_cnt`=0.
- Step latency: `enable` sampled high at edge k updates `phase` after edge k.
- Pulse timing with `enable` held high from the first edge after reset:
  - The first wrap occurs at enabled edge P, where P = LENGTH (ring) or 2·LENGTH (Johnson).
  - `count_pulse` is high in the cycles after enabled edges P, 2P, 3P, and so on.
  - `phase` returns to the reset value at the same edge.
- `wrap_cnt` updates on the same edge as `count_pulse` rises.
- Pausing `enable` for n cycles delays every later pulse by exactly n cycles.
- Asserting `rst` or `clear` at the wrap edge suppresses that pulse and that increment.

## Configuration
- `CSR_WRAP_CNT_EN` defined: the `wrap_cnt` register and saturation logic are built as described above.
- Undefined: `wrap_cnt` is tied to 0, no counter flops exist, and `WRAP_W` only sizes the port. Every other output is cycle-identical.

## Structure
- Package `csr_pkg` holds:
  - `MODE_RING`=0 and `MODE_JOHNSON`=1 constants.
  - A function returning the reset phase for a given mode and length.
  - A function returning the period for a given mode and length.
- One sub-module, `csr_wrap_counter`: a saturating WRAP_W-bit counter with sync reset, `clear` and `inc`. It is instantiated only under `CSR_WRAP_CNT_EN`.
- Top level contains the shift register, the terminal-phase decode, and the pulse register.

## Test plan
- Ring, LENGTH=8, `enable` held high after reset: `phase` runs 0x01, 0x02, … 0x80, 0x01. `count_pulse` is high one cycle after enabled edges 8, 16 and 24, and low otherwise.
- Johnson, LENGTH=4: `phase` runs 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000. `count_pulse` repeats with period 8.
- Ring, LENGTH=8, `enable` low for 5 cycles at `phase`=0x08: `phase` holds at 0x08 with no pulse, and the next pulse arrives 5 cycles later than nominal.
- `clear` at `phase`=0x80 with `enable` high: next `phase`=0x01, `count_pulse` stays 0, `wrap_cnt`=0. Asserting `rst` and `clear` together gives the same result.
- `rst` asserted mid-operation at `phase`=0x40: next cycle `phase`=0x01, `count_pulse`=0, `wrap_cnt`=0. The following pulse occurs 8 enabled edges later.
- `CSR_WRAP_CNT_EN` with `WRAP_W`=2, five wraps: `wrap_cnt` reads 1, 2, 3, 3, 3. With the macro undefined, `wrap_cnt` reads 0 throughout.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared constants and elaboration helpers for the shift-register counter family.
package csr_pkg;

  localparam int MODE_RING    = 0;
  localparam int MODE_JOHNSON = 1;

  // Upper bound on the register length the helpers below can describe.
  localparam int CSR_MAX_LEN = 256;

  function automatic logic [CSR_MAX_LEN-1:0] csr_reset_phase(input int mode, input int length);
    logic [CSR_MAX_LEN-1:0] ph;
    ph = '0;
    if (mode == MODE_RING && length >= 2 && length <= CSR_MAX_LEN) begin
      ph[0] = 1'b1;
    end
    return ph;
  endfunction

  function automatic int csr_period(input int mode, input int length);
    return (mode == MODE_JOHNSON) ? 2 * length : length;
  endfunction

endpackage

// File: rtl/csr_wrap_counter.sv
// Saturating wrap counter: +1 per inc, sticks at all-ones, clear/rst return it to zero.
// One-cycle update latency; clear overrides inc.
module csr_wrap_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/param_shift_counter.sv
// Ring/Johnson shift-register divider emitting a registered one-cycle pulse on every wrap.
// CSR_WRAP_CNT_EN builds the saturating wrap counter; otherwise wrap_cnt is tied to zero.
module param_shift_counter
  import csr_pkg::*;
#(
  parameter int LENGTH = 8,
  parameter int MODE   = 0,
  parameter int WRAP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              clear,
  output logic              count_pulse,
  output logic [LENGTH-1:0] phase,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam logic [CSR_MAX_LEN-1:0] RESET_FULL  = csr_reset_phase(MODE, LENGTH);
  localparam logic [LENGTH-1:0]      RESET_PHASE = RESET_FULL[LENGTH-1:0];
  localparam int                     PERIOD      = csr_period(MODE, LENGTH);

  generate
    if (LENGTH < 2 || LENGTH > CSR_MAX_LEN || PERIOD < 2) begin : g_bad_length
      $error("param_shift_counter: LENGTH out of range");
    end
    if (MODE != MODE_RING && MODE != MODE_JOHNSON) begin : g_bad_mode
      $error("param_shift_counter: MODE must be ring or Johnson");
    end
  endgenerate

  logic [LENGTH-1:0] phase_q;
  logic [LENGTH-1:0] phase_d;
  logic [LENGTH-1:0] step_val;
  logic              pulse_q;
  logic              pulse_d;
  logic              terminal;
  logic              wrap;

  // Terminal phase is the one whose next step lands back on the reset phase.
  generate
    if (MODE == MODE_JOHNSON) begin : g_johnson
      localparam logic [LENGTH-1:0] JOHNSON_TERM = {1'b1, {(LENGTH-1){1'b0}}};
      assign step_val = {phase_q[LENGTH-2:0], ~phase_q[LENGTH-1]};
      assign terminal = (phase_q == JOHNSON_TERM);
    end else begin : g_ring
      assign step_val = {phase_q[LENGTH-2:0], phase_q[LENGTH-1]};
      assign terminal = phase_q[LENGTH-1];
    end
  endgenerate

  assign wrap = enable & ~clear & terminal;

  always_comb begin
    phase_d = phase_q;
    pulse_d = 1'b0;
    if (clear) begin
      phase_d = RESET_PHASE;
    end else if (enable) begin
      phase_d = step_val;
      pulse_d = wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= RESET_PHASE;
      pulse_q <= 1'b0;
    end else begin
      phase_q <= phase_d;
      pulse_q <= pulse_d;
    end
  end

  assign phase       = phase_q;
  assign count_pulse = pulse_q;

`ifdef CSR_WRAP_CNT_EN
  csr_wrap_counter #(
    .W (WRAP_W)
  ) u_wrap_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   (wrap),
    .cnt   (wrap_cnt)
  );
`else
  assign wrap_cnt = '0;
`endif

endmodule

// File: tb/tb_param_shift_counter.sv
// Directed bench for param_shift_counter: ring L=8 and Johnson L=4 run side by side against a step-count model.
module tb_param_shift_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst    = 1'b1;
  logic enable = 1'b0;
  logic clear  = 1'b0;

  logic       r_pulse;
  logic [7:0] r_phase;
  logic [1:0] r_wrap;
  logic       j_pulse;
  logic [3:0] j_phase;
  logic [7:0] j_wrap;

  param_shift_counter #(.LENGTH(8), .MODE(0), .WRAP_W(2)) u_ring (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .clear       (clear),
    .count_pulse (r_pulse),
    .phase       (r_phase),
    .wrap_cnt    (r_wrap)
  );

  param_shift_counter #(.LENGTH(4), .MODE(1), .WRAP_W(8)) u_john (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .clear       (clear),
    .count_pulse (j_pulse),
    .phase       (j_phase),
    .wrap_cnt    (j_wrap)
  );

`ifdef CSR_WRAP_CNT_EN
  localparam bit WC_ON = 1'b1;
`else
  localparam bit WC_ON = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  // Model state: enabled steps since the reset phase, pulse flag, wrap count.
  int m_rk = 0, m_rw = 0, m_jk = 0, m_jw = 0;
  bit m_rp = 1'b0, m_jp = 1'b0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic int ring_phase(input int k);
    return 1 << k;
  endfunction

  function automatic int john_phase(input int k);
    if (k <= 4) return (1 << k) - 1;
    return (15 << (k - 4)) & 15;
  endfunction

  task automatic model_step(input logic e, input logic c, input logic r);
    if (r || c) begin
      m_rk = 0; m_rp = 1'b0; m_rw = 0;
      m_jk = 0; m_jp = 1'b0; m_jw = 0;
    end else if (e) begin
      m_rp = (m_rk == 7);
      if (m_rp) begin m_rk = 0; if (m_rw < 3) m_rw++; end else m_rk++;
      m_jp = (m_jk == 7);
      if (m_jp) begin m_jk = 0; if (m_jw < 255) m_jw++; end else m_jk++;
    end else begin
      m_rp = 1'b0;
      m_jp = 1'b0;
    end
  endtask

  // Apply inputs for one edge, then check every output against the model just after it.
  task automatic cyc(input logic e, input logic c, input logic r);
    enable = e; clear = c; rst = r;
    @(posedge clk);
    #1;
    model_step(e, c, r);
    chk("ring_phase", int'(r_phase), ring_phase(m_rk));
    chk("ring_pulse", int'(r_pulse), int'(m_rp));
    chk("ring_wrap",  int'(r_wrap),  WC_ON ? m_rw : 0);
    chk("john_phase", int'(j_phase), john_phase(m_jk));
    chk("john_pulse", int'(j_pulse), int'(m_jp));
    chk("john_wrap",  int'(j_wrap),  WC_ON ? m_jw : 0);
  endtask

  logic [7:0] rseq [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [3:0] jseq [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
  int         wsat [6] = '{0, 1, 2, 3, 3, 3};

  initial begin
    int i;
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("reset_ring_phase", int'(r_phase), 8'h01);
    chk("reset_ring_pulse", int'(r_pulse), 0);
    chk("reset_ring_wrap",  int'(r_wrap),  0);
    chk("reset_john_phase", int'(j_phase), 0);

    // Free run: five ring wraps exercise 2-bit saturation.
    for (int n = 1; n <= 40; n++) begin
      cyc(1'b1, 1'b0, 1'b0);
      chk("run_ring_phase", int'(r_phase), int'(rseq[n % 8]));
      chk("run_ring_pulse", int'(r_pulse), (n % 8 == 0) ? 1 : 0);
      chk("run_ring_wrap",  int'(r_wrap),  WC_ON ? wsat[n / 8] : 0);
      chk("run_john_phase", int'(j_phase), int'(jseq[n % 8]));
      chk("run_john_pulse", int'(j_pulse), (n % 8 == 0) ? 1 : 0);
    end

    // Pause five cycles at 0x08; pulse must come after five more enabled edges.
    for (int n = 0; n < 3; n++) cyc(1'b1, 1'b0, 1'b0);
    chk("pause_start_phase", int'(r_phase), 8'h08);
    for (int n = 0; n < 5; n++) begin
      cyc(1'b0, 1'b0, 1'b0);
      chk("pause_hold_phase", int'(r_phase), 8'h08);
      chk("pause_hold_pulse", int'(r_pulse), 0);
    end
    i = 0;
    while (!r_pulse && i < 20) begin
      cyc(1'b1, 1'b0, 1'b0);
      i++;
    end
    chk("pause_edges_to_pulse", i, 5);

    // Enable low while terminal: no pulse until the step is actually taken.
    for (int n = 0; n < 7; n++) cyc(1'b1, 1'b0, 1'b0);
    chk("term_phase", int'(r_phase), 8'h80);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("term_hold_phase", int'(r_phase), 8'h80);
    chk("term_hold_pulse", int'(r_pulse), 0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("term_step_pulse", int'(r_pulse), 1);
    chk("term_step_phase", int'(r_phase), 8'h01);

    // Clear at terminal phase with enable high.
    for (int n = 0; n < 7; n++) cyc(1'b1, 1'b0, 1'b0);
    chk("clr_pre_phase", int'(r_phase), 8'h80);
    cyc(1'b1, 1'b1, 1'b0);
    chk("clr_phase", int'(r_phase), 8'h01);
    chk("clr_pulse", int'(r_pulse), 0);
    chk("clr_wrap",  int'(r_wrap),  0);

    // Reset and clear together at terminal phase.
    for (int n = 0; n < 7; n++) cyc(1'b1, 1'b0, 1'b0);
    chk("rstclr_pre_phase", int'(r_phase), 8'h80);
    cyc(1'b1, 1'b1, 1'b1);
    chk("rstclr_phase", int'(r_phase), 8'h01);
    chk("rstclr_pulse", int'(r_pulse), 0);
    chk("rstclr_wrap",  int'(r_wrap),  0);

    // Reset mid-run at 0x40, then a full period to the next pulse.
    for (int n = 0; n < 6; n++) cyc(1'b1, 1'b0, 1'b0);
    chk("rstmid_pre_phase", int'(r_phase), 8'h40);
    cyc(1'b1, 1'b0, 1'b1);
    chk("rstmid_phase", int'(r_phase), 8'h01);
    chk("rstmid_pulse", int'(r_pulse), 0);
    chk("rstmid_wrap",  int'(r_wrap),  0);
    i = 0;
    while (!r_pulse && i < 20) begin
      cyc(1'b1, 1'b0, 1'b0);
      i++;
    end
    chk("rstmid_edges_to_pulse", i, 8);
    chk("rstmid_wrap_after", int'(r_wrap), WC_ON ? 1 : 0);

    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
